// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, companion of the UART transmitter.
//
// The asynchronous rx line is brought into the clk domain through a two-flop
// synchronizer. A small FSM qualifies the start bit at its middle, then takes
// one sample per bit period for the eight data bits (LSB first) and the stop
// bit. A good frame updates data_out and pulses valid for one cycle. A stop
// bit read as 0 pulses frame_err, and the receiver then waits for the line to
// return high before it looks for a new start bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is expected between the last data bit
//   and the stop bit, and the parity_err output port is added. A parity
//   mismatch pulses parity_err at the stop-bit sample and suppresses valid.
//   frame_err is evaluated independently of the parity result.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 4, same value as the transmitter)
//
// Ports:
//   clk         system clock, rising-edge
//   reset       synchronous active-high reset
//   rx          asynchronous serial input, idles high
//   data_out    last correctly received byte, held between frames
//   valid       one-cycle pulse, data_out updated on the same edge
//   busy        high whenever the receiver is not idle
//   parity_err  (UART_RX_PARITY_EN only) one-cycle parity mismatch pulse
//   frame_err   one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    // Counter wide enough to hold CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Middle of the start bit (integer division) and last count of a bit.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // FSM encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd5;
`endif

`ifdef UART_RX_PARITY_EN
    // True when the eight data bits plus the received parity bit hold an
    // even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] data,
                                            input logic       par_bit);
        return ((^data) ^ par_bit) == 1'b0;
    endfunction
`endif

    // Synchronizer: sync_meta_r may go metastable, rx_s is the clean copy.
    logic             sync_meta_r;
    logic             rx_s;

    logic [2:0]       state_r;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic             par_bit_r;
    logic             par_bit_nxt;
    logic             parity_err_nxt;
`endif

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_r <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            sync_meta_r <= rx;
            rx_s        <= sync_meta_r;
        end
    end

    // Next-state, datapath and output-pulse logic of the receive FSM.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        idx_nxt       = idx_r;
        shift_nxt     = shift_r;
        data_nxt      = data_out;
        valid_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt    = par_bit_r;
        parity_err_nxt = 1'b0;
`endif

        case (state_r)
            ST_IDLE: begin
                if (rx_s == 1'b0) begin
                    state_nxt = ST_START;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_START: begin
                // Re-check the line at mid start bit; a short low pulse is
                // a glitch and is dropped silently.
                if (cnt_r == HALF_CNT) begin
                    cnt_nxt = CNT_ZERO;
                    if (rx_s == 1'b0) begin
                        state_nxt = ST_DATA;
                        idx_nxt   = 3'd0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                // Counting restarts at mid start bit, so each sample lands
                // one full bit period later, near the middle of the bit.
                if (cnt_r == LAST_CNT) begin
                    shift_nxt[idx_r] = rx_s;
                    cnt_nxt          = CNT_ZERO;
                    if (idx_r == 3'd7) begin
                        idx_nxt   = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        idx_nxt = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == LAST_CNT) begin
                    par_bit_nxt = rx_s;
                    cnt_nxt     = CNT_ZERO;
                    state_nxt   = ST_STOP;
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
`endif

            ST_STOP: begin
                // Sampled about half a bit before the stop bit ends, which
                // leaves room to catch a back-to-back start edge.
                if (cnt_r == LAST_CNT) begin
                    cnt_nxt = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
                    parity_err_nxt = ~even_parity_ok(shift_r, par_bit_r);
`endif
                    if (rx_s == 1'b1) begin
                        state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity_ok(shift_r, par_bit_r)) begin
                            data_nxt  = shift_r;
                            valid_nxt = 1'b1;
                        end else begin
                            valid_nxt = 1'b0;
                        end
`else
                        data_nxt  = shift_r;
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end

            ST_WAIT_HIGH: begin
                // Break or stuck-low line: no new frame until it idles high.
                if (rx_s == 1'b1) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT_HIGH;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = CNT_ZERO;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    // State, datapath and registered outputs; busy follows the next state so
    // it drops on the same edge that valid rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            idx_r     <= 3'd0;
            shift_r   <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            idx_r     <= idx_nxt;
            shift_r   <= shift_nxt;
            data_out  <= data_nxt;
            valid     <= valid_nxt;
            busy      <= (state_nxt != ST_IDLE);
            frame_err <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit_r  <= par_bit_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (CLKS_PER_BIT = 8).
// A serial driver produces frames bit by bit; a monitor logs every output
// pulse with its cycle number; an event model built from the frame rules
// predicts the pulse type, cycle and data_out value of each frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int C = 8;
    localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    // Cycles from edge A (start edge captured) to the output pulse.
    localparam int LAT = 2 + H + 1 + 9 * C + PAR_EN * C;
    localparam int FRAME = (10 + PAR_EN) * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       v;
        logic       f;
        logic       p;
        logic [7:0] d;
    } ev_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         extra;
        int         gap;
        logic       exp_v;
        logic       exp_f;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every output pulse together with the cycle it was seen in.
    always @(negedge clk) begin
        if (valid || frame_err || parity_err) begin
            mon_e.cyc = cyc;
            mon_e.v   = valid;
            mon_e.f   = frame_err;
            mon_e.p   = parity_err;
            mon_e.d   = data_out;
            got_q.push_back(mon_e);
        end
    end

    initial begin
        #(2000000);
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic idle(input int k);
        rx = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    // Drive one frame starting at the current negedge and record the
    // expected outcome. Leaves rx high on return.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_b, input int extra_low,
                              output int n);
        ev_t  e;
        logic ok;
        n     = cyc;
        ok    = (PAR_EN == 0) || (par_b == even_par(d));
        e.cyc = n + 1 + LAT;
        e.v   = stop_b && ok;
        e.f   = !stop_b;
        e.p   = (PAR_EN != 0) && !ok;
        if (e.v) last_good = d;
        e.d   = last_good;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk);
        end
        if (PAR_EN != 0) begin
            rx = par_b;
            repeat (C) @(negedge clk);
        end
        rx = stop_b;
        repeat (C) @(negedge clk);
        if (extra_low > 0) begin
            rx = 1'b0;
            repeat (extra_low) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic check_events(input string name);
        int n;
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_cyc"},   32'(got_q[i].cyc), 32'(exp_q[i].cyc));
            check({name, "_valid"}, 32'(got_q[i].v),   32'(exp_q[i].v));
            check({name, "_ferr"},  32'(got_q[i].f),   32'(exp_q[i].f));
            check({name, "_perr"},  32'(got_q[i].p),   32'(exp_q[i].p));
            check({name, "_data"},  32'(got_q[i].d),   32'(exp_q[i].d));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         n;
        int         m;
        logic [7:0] d;
        logic       stop_b;
        logic       par_b;
        int         extra;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 1'b1, 0,  6,  1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 10, 6,  1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'h01, 1'b1, 0,  0,  1'b1, 1'b0, 8'h01};
        vecs[3] = '{8'h80, 1'b1, 0,  3,  1'b1, 1'b0, 8'h80};
        vecs[4] = '{8'hFE, 1'b0, 0,  5,  1'b0, 1'b1, 8'h80};
        vecs[5] = '{8'h7F, 1'b1, 0,  12, 1'b1, 1'b0, 8'h7F};

        // Reset state.
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_data",  32'(data_out),   32'h00);
        check("rst_valid", 32'(valid),      32'h0);
        check("rst_busy",  32'(busy),       32'h0);
        check("rst_ferr",  32'(frame_err),  32'h0);
        check("rst_perr",  32'(parity_err), 32'h0);
        reset = 1'b0;
        idle(5);

        // Abort: reset during bit 3 of 0x12, then a clean 0x3C.
        b  = 8'h12;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = b[3];
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rx    = 1'b1;
        reset = 1'b0;
        idle(20);
        send_frame(8'h3C, 1'b1, even_par(8'h3C), 0, n);
        idle(20);
        check("abort_data", 32'(data_out), 32'h3C);
        check_events("abort");

        // 0xB7 with cycle-exact busy/valid checks.
        fork
            send_frame(8'hB7, 1'b1, even_par(8'hB7), 0, n);
            begin
                m = cyc;
                wait_cyc(m + 1 + 3);
                check("b7_busy_a3", 32'(busy), 32'h1);
                wait_cyc(m + LAT);
                check("b7_busy_pre", 32'(busy), 32'h1);
                check("b7_valid_pre", 32'(valid), 32'h0);
                wait_cyc(m + 1 + LAT);
                check("b7_valid", 32'(valid), 32'h1);
                check("b7_busy_end", 32'(busy), 32'h0);
                check("b7_data", 32'(data_out), 32'hB7);
                wait_cyc(m + 2 + LAT);
                check("b7_valid_post", 32'(valid), 32'h0);
            end
        join
        idle(10);
        check_events("b7");

        // Glitch: two low cycles only.
        n  = cyc;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        wait_cyc(n + 4);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        wait_cyc(n + 8);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        idle(10);
        check_events("glitch");

        // Frame error with line held low 40 more cycles.
        send_frame(8'h55, 1'b0, even_par(8'h55), 40, n);
        m = cyc;
        wait_cyc(m + 2);
        check("ferr_busy_hold", 32'(busy), 32'h1);
        wait_cyc(m + 3);
        check("ferr_busy_rel", 32'(busy), 32'h0);
        check("ferr_data_kept", 32'(data_out), 32'hB7);
        idle(10);
        check_events("ferr");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, even_par(8'h00), 0, n);
        send_frame(8'hFF, 1'b1, even_par(8'hFF), 0, n);
        idle(20);
        if (got_q.size() >= 2) begin
            check("b2b_spacing", 32'(got_q[1].cyc - got_q[0].cyc), 32'(FRAME));
        end else begin
            check("b2b_pulses", 32'(got_q.size()), 32'd2);
        end
        check_events("b2b");

`ifdef UART_RX_PARITY_EN
        send_frame(8'hB7, 1'b1, 1'b0, 0, n);
        idle(10);
        check("par_ok_data", 32'(data_out), 32'hB7);
        check_events("par_ok");
        send_frame(8'hB7, 1'b1, 1'b1, 0, n);
        idle(10);
        check_events("par_bad");
`endif

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].d, vecs[i].stop, even_par(vecs[i].d), vecs[i].extra, n);
            check("tbl_count", 32'(got_q.size()), 32'd1);
            if (got_q.size() >= 1) begin
                check("tbl_valid", 32'(got_q[0].v),   32'(vecs[i].exp_v));
                check("tbl_ferr",  32'(got_q[0].f),   32'(vecs[i].exp_f));
                check("tbl_perr",  32'(got_q[0].p),   32'h0);
                check("tbl_cyc",   32'(got_q[0].cyc), 32'(n + 1 + LAT));
            end
            check("tbl_data", 32'(data_out), 32'(vecs[i].exp_data));
            got_q.delete();
            exp_q.delete();
            idle(vecs[i].gap);
        end
        idle(4);

        // Randomized frames against the event model.
        for (int i = 0; i < 40; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 4) != 0);
            par_b  = even_par(d);
            if (PAR_EN != 0 && $urandom_range(0, 3) == 0) par_b = ~par_b;
            extra  = stop_b ? 0 : int'($urandom_range(0, 20));
            send_frame(d, stop_b, par_b, extra, n);
            idle(stop_b ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8)));
        end
        idle(20);
        check("rand_data_final", 32'(data_out), 32'(last_good));
        check_events("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
